// File: rtl/gray_counter_mod.sv
// Parametrised Gray-code counter: width/modulo, enable, direction, load, wrap or saturate.
// Optional SVA checker compiled in when GRAY_COUNTER_MOD_ASSERT_EN is defined.

`ifdef GRAY_COUNTER_MOD_ASSERT_EN
module gray_counter_mod_sva #(
  parameter int WIDTH  = 12,
  parameter int MODULO = 0,
  parameter int SAT    = 0
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic             load,
  input logic [WIDTH-1:0] bin_o,
  input logic [WIDTH-1:0] gray_o,
  input logic             wrap_o,
  input logic             sat_o,
  input logic             zero_o
);
  localparam logic [WIDTH-1:0] MAX_VAL = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);

  p_coh: assert property (@(posedge clk) disable iff (!rst)
    gray_o == (bin_o ^ (bin_o >> 1)));

  p_range: assert property (@(posedge clk) disable iff (!rst)
    bin_o <= MAX_VAL);

  if (MODULO == 0) begin : g_onebit
    p_onebit: assert property (@(posedge clk) disable iff (!rst)
      $past(en && !load && !sat_o) |-> ($countones(gray_o ^ $past(gray_o)) <= 1));
  end

  if (SAT == 0) begin : g_live
    p_live: assert property (@(posedge clk) disable iff (!rst)
      (s_eventually always (rst && en && !load)) implies (always s_eventually zero_o));
  end

  p_wrap: assert property (@(posedge clk) disable iff (!rst)
    wrap_o |-> $past(en && !load));
endmodule
`endif

module gray_counter_mod #(
  parameter int WIDTH  = 12,
  parameter int MODULO = 0,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  output logic             sat_o,
  output logic             zero_o
);
  localparam logic [WIDTH-1:0] MAX_VAL  = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;
  logic             sat_r;
  logic             zero_r;
  logic [WIDTH-1:0] next_bin_s;
  logic             next_wrap_s;
  logic             next_sat_s;
  logic             at_max_s;
  logic             at_zero_s;

  assign at_max_s  = (bin_r == MAX_VAL);
  assign at_zero_s = (bin_r == ZERO_VAL);

  // Next-state selection with priority load > en > hold.
  always_comb begin
    next_bin_s  = bin_r;
    next_wrap_s = 1'b0;
    next_sat_s  = sat_r;
    if (load) begin
      next_bin_s  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      next_sat_s  = 1'b0;
    end else if (en) begin
      if (up) begin
        if (!at_max_s) begin
          next_bin_s = bin_r + ONE_VAL;
          next_sat_s = 1'b0;
        end else if (SAT == 0) begin
          next_bin_s  = ZERO_VAL;
          next_wrap_s = 1'b1;
          next_sat_s  = 1'b0;
        end else begin
          next_bin_s = bin_r;
          next_sat_s = 1'b1;
        end
      end else begin
        if (!at_zero_s) begin
          next_bin_s = bin_r - ONE_VAL;
          next_sat_s = 1'b0;
        end else if (SAT == 0) begin
          next_bin_s  = MAX_VAL;
          next_wrap_s = 1'b1;
          next_sat_s  = 1'b0;
        end else begin
          next_bin_s = bin_r;
          next_sat_s = 1'b1;
        end
      end
    end else begin
      next_bin_s  = bin_r;
      next_wrap_s = 1'b0;
      next_sat_s  = sat_r;
    end
  end

  // State registers; Gray and zero flag derive from the same next value as the binary count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_r  <= ZERO_VAL;
      gray_r <= ZERO_VAL;
      wrap_r <= 1'b0;
      sat_r  <= 1'b0;
      zero_r <= 1'b1;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= bin2gray(next_bin_s);
      wrap_r <= next_wrap_s;
      sat_r  <= next_sat_s;
      zero_r <= (next_bin_s == ZERO_VAL);
    end
  end

  assign bin_o  = bin_r;
  assign gray_o = gray_r;
  assign wrap_o = wrap_r;
  assign sat_o  = sat_r;
  // zero_r resets high so the flag is valid the instant reset releases.
  assign zero_o = rst & zero_r;

`ifdef GRAY_COUNTER_MOD_ASSERT_EN
  gray_counter_mod_sva #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO),
    .SAT    (SAT)
  ) u_sva (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .bin_o  (bin_r),
    .gray_o (gray_r),
    .wrap_o (wrap_r),
    .sat_o  (sat_r),
    .zero_o (zero_o)
  );
`endif
endmodule

// File: tb/tb_gray_counter_mod.sv
// Bench for gray_counter_mod: four instances (default, MODULO=10, WIDTH=4 SAT=1, MODULO=100).
module tb_gray_counter_mod;
  logic clk;
  logic rst;
  logic [3:0] en_v;
  logic [3:0] up_v;
  logic [3:0] load_v;
  logic [11:0] lv [4];
  logic [11:0] bin0, gray0, bin1, gray1, bin3, gray3;
  logic [3:0]  bin2, gray2;
  logic [3:0]  wrap_v, sat_v, zero_v;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    int         d;
    logic       e;
    logic       u;
    logic       l;
    logic [11:0] lval;
    logic [11:0] bin;
    logic       wrap;
    logic       sat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  gray_counter_mod u_d0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]), .load_val(lv[0]),
    .bin_o(bin0), .gray_o(gray0), .wrap_o(wrap_v[0]), .sat_o(sat_v[0]), .zero_o(zero_v[0]));
  gray_counter_mod #(.MODULO(10)) u_d1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]), .load_val(lv[1]),
    .bin_o(bin1), .gray_o(gray1), .wrap_o(wrap_v[1]), .sat_o(sat_v[1]), .zero_o(zero_v[1]));
  gray_counter_mod #(.WIDTH(4), .SAT(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]), .load_val(lv[2][3:0]),
    .bin_o(bin2), .gray_o(gray2), .wrap_o(wrap_v[2]), .sat_o(sat_v[2]), .zero_o(zero_v[2]));
  gray_counter_mod #(.MODULO(100)) u_d3 (
    .clk(clk), .rst(rst), .en(en_v[3]), .up(up_v[3]), .load(load_v[3]), .load_val(lv[3]),
    .bin_o(bin3), .gray_o(gray3), .wrap_o(wrap_v[3]), .sat_o(sat_v[3]), .zero_o(zero_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] get_bin(int d);
    case (d)
      0: return bin0;
      1: return bin1;
      2: return {8'h00, bin2};
      default: return bin3;
    endcase
  endfunction

  function automatic logic [11:0] get_gray(int d);
    case (d)
      0: return gray0;
      1: return gray1;
      2: return {8'h00, gray2};
      default: return gray3;
    endcase
  endfunction

  function automatic vec_t mk(string n, int d, logic e, logic u, logic l,
                              logic [11:0] lval, logic [11:0] b, logic w, logic s);
    vec_t v;
    v.name = n; v.d = d; v.e = e; v.u = u; v.l = l;
    v.lval = lval; v.bin = b; v.wrap = w; v.sat = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one record, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [11:0] eg;
    en_v = 4'b0000;
    load_v = 4'b0000;
    en_v[v.d] = v.e;
    up_v[v.d] = v.u;
    load_v[v.d] = v.l;
    lv[v.d] = v.lval;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    eg = e.bin ^ (e.bin >> 1);
    check({e.name, " bin"}, {20'h0, get_bin(e.d)}, {20'h0, e.bin});
    check({e.name, " gray"}, {20'h0, get_gray(e.d)}, {20'h0, eg});
    check({e.name, " wrap"}, {31'h0, wrap_v[e.d]}, {31'h0, e.wrap});
    check({e.name, " sat"}, {31'h0, sat_v[e.d]}, {31'h0, e.sat});
  endtask

  initial begin
    logic [11:0] prev_gray;
    logic [11:0] exp_bin;
    rst = 1'b0;
    en_v = 4'b0000;
    up_v = 4'b0000;
    load_v = 4'b0000;
    for (int k = 0; k < 4; k++) lv[k] = 12'h000;

    // reset state
    #23;
    for (int k = 0; k < 4; k++) begin
      check("rst bin", {20'h0, get_bin(k)}, 32'h0);
      check("rst gray", {20'h0, get_gray(k)}, 32'h0);
      check("rst wrap", {31'h0, wrap_v[k]}, 32'h0);
      check("rst sat", {31'h0, sat_v[k]}, 32'h0);
      check("rst zero low", {31'h0, zero_v[k]}, 32'h0);
    end
    rst = 1'b1;
    #1;
    check("release zero", {28'h0, zero_v}, 32'hF);

    // free-running full period on the default instance
    prev_gray = 12'h000;
    for (int i = 1; i <= 4097; i++) begin
      exp_bin = 12'(i % 4096);
      apply(mk("run", 0, 1'b1, 1'b1, 1'b0, 12'h000, exp_bin, (i == 4096), 1'b0));
      check("run onebit", $countones(gray0 ^ prev_gray), 32'd1);
      if (i == 3) check("gray at 3", {20'h0, gray0}, 32'h002);
      prev_gray = gray0;
    end

    // MODULO=10 up then down across zero
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk("m10 up", 1, 1'b1, 1'b1, 1'b0, 12'h000, 12'(k), 1'b0, 1'b0));
    tbl.push_back(mk("m10 wrap", 1, 1'b1, 1'b1, 1'b0, 12'h000, 12'd0, 1'b1, 1'b0));
    tbl.push_back(mk("m10 dn wrap", 1, 1'b1, 1'b0, 1'b0, 12'h000, 12'd9, 1'b1, 1'b0));
    tbl.push_back(mk("m10 dn", 1, 1'b1, 1'b0, 1'b0, 12'h000, 12'd8, 1'b0, 1'b0));
    // WIDTH=4 SAT=1 saturation
    tbl.push_back(mk("sat load", 2, 1'b0, 1'b0, 1'b1, 12'd14, 12'd14, 1'b0, 1'b0));
    tbl.push_back(mk("sat up", 2, 1'b1, 1'b1, 1'b0, 12'h000, 12'd15, 1'b0, 1'b0));
    tbl.push_back(mk("sat block1", 2, 1'b1, 1'b1, 1'b0, 12'h000, 12'd15, 1'b0, 1'b1));
    tbl.push_back(mk("sat hold", 2, 1'b0, 1'b1, 1'b0, 12'h000, 12'd15, 1'b0, 1'b1));
    tbl.push_back(mk("sat block2", 2, 1'b1, 1'b1, 1'b0, 12'h000, 12'd15, 1'b0, 1'b1));
    tbl.push_back(mk("sat down", 2, 1'b1, 1'b0, 1'b0, 12'h000, 12'd14, 1'b0, 1'b0));
    // MODULO=100 load clamp and load priority over en
    tbl.push_back(mk("m100 clamp", 3, 1'b1, 1'b1, 1'b1, 12'hFFF, 12'd99, 1'b0, 1'b0));
    tbl.push_back(mk("m100 wrap", 3, 1'b1, 1'b1, 1'b0, 12'h000, 12'd0, 1'b1, 1'b0));
    tbl.push_back(mk("m100 ld en", 3, 1'b1, 1'b0, 1'b1, 12'd5, 12'd5, 1'b0, 1'b0));
    // enable toggling from 7
    tbl.push_back(mk("ld7", 0, 1'b0, 1'b1, 1'b1, 12'd7, 12'd7, 1'b0, 1'b0));
    tbl.push_back(mk("en1a", 0, 1'b1, 1'b1, 1'b0, 12'h000, 12'd8, 1'b0, 1'b0));
    tbl.push_back(mk("en0a", 0, 1'b0, 1'b1, 1'b0, 12'h000, 12'd8, 1'b0, 1'b0));
    tbl.push_back(mk("en1b", 0, 1'b1, 1'b1, 1'b0, 12'h000, 12'd9, 1'b0, 1'b0));
    tbl.push_back(mk("en0b", 0, 1'b0, 1'b1, 1'b0, 12'h000, 12'd9, 1'b0, 1'b0));
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

    check("m100 gray82", {20'h0, 12'd99 ^ 12'd49}, 32'd82);

    // asynchronous reset mid-count
    apply(mk("ld 5a5", 0, 1'b0, 1'b1, 1'b1, 12'h5A5, 12'h5A5, 1'b0, 1'b0));
    apply(mk("cnt 5a6", 0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h5A6, 1'b0, 1'b0));
    #2;
    rst = 1'b0;
    #1;
    check("arst bin", {20'h0, bin0}, 32'h0);
    check("arst gray", {20'h0, gray0}, 32'h0);
    check("arst wrap", {31'h0, wrap_v[0]}, 32'h0);
    check("arst zero", {31'h0, zero_v[0]}, 32'h0);
    @(posedge clk);
    #1;
    check("arst held bin", {20'h0, bin0}, 32'h0);
    check("arst held zero", {31'h0, zero_v[0]}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst release zero", {31'h0, zero_v[0]}, 32'h1);
    apply(mk("restart", 0, 1'b1, 1'b1, 1'b0, 12'h000, 12'd1, 1'b0, 1'b0));
    check("restart zero", {31'h0, zero_v[0]}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/gray_counter_mod.md
Name: gray_counter_mod

Overview:
- Parametrised Gray-code counter; successor to the fixed 12-bit free-running Gray counter.
- Adds the following over the fixed counter:
  - generic width and modulo
  - count enable
  - up/down direction
  - synchronous load
  - wrap or saturate mode
  - a wrap pulse and a saturation flag
- Gray output is registered coherently with the binary count: gray_o always encodes bin_o of the same cycle, with no one-cycle lag.
- Used as a pointer/sequence source and as a model-checking benchmark. Liveness is: counter keeps returning to zero while enabled.

Parameters:
- WIDTH, 12, counter width in bits (>= 2).
- MODULO, 0, count modulus; 0 means 2^WIDTH, otherwise 2..2^WIDTH.
- SAT, 0, 0 = wrap at boundaries, 1 = saturate at boundaries.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable, one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- bin_o  output  WIDTH  registered binary count.
- gray_o  output  WIDTH  registered Gray code of bin_o.
- wrap_o  output  1  registered one-cycle pulse after a wrap step.
- sat_o  output  1  registered flag: last step was blocked by saturation.
- zero_o  output  1  bin_o == 0, gated low while rst is low.

Behaviour:
- MAX = (MODULO == 0) ? 2^WIDTH-1 : MODULO-1. All arithmetic is WIDTH bits, unsigned.
- Reset (rst low, asynchronous):
  - bin_o = 0, gray_o = 0, wrap_o = 0, sat_o = 0.
  - zero_o = 0 while rst is low; equals (bin_o == 0) once rst is high.
- Priority per rising edge: load > en > hold.
- load = 1:
  - bin_o <= min(load_val, MAX); gray_o follows.
  - wrap_o <= 0, sat_o <= 0.
  - en and up are ignored that cycle.
- en = 1, up = 1:
  - bin_o < MAX: bin_o <= bin_o + 1; wrap_o <= 0; sat_o <= 0.
  - bin_o == MAX and SAT = 0: bin_o <= 0; wrap_o <= 1.
  - bin_o == MAX and SAT = 1: bin_o holds; sat_o <= 1.
- en = 1, up = 0:
  - bin_o > 0: bin_o <= bin_o - 1; wrap_o <= 0; sat_o <= 0.
  - bin_o == 0 and SAT = 0: bin_o <= MAX; wrap_o <= 1.
  - bin_o == 0 and SAT = 1: bin_o holds; sat_o <= 1.
- en = 0, load = 0: bin_o and gray_o hold; wrap_o <= 0; sat_o holds.
- gray_o is the registered value of next_bin ^ (next_bin >> 1), computed from the same next-state value as bin_o. Invariant at every edge: gray_o == bin_o ^ (bin_o >> 1).
- Single-bit Gray change per step is guaranteed for all non-wrap steps. It is guaranteed on wrap steps only when MODULO == 0. For non-power-of-two MODULO it is not guaranteed at wrap.
- Direction change takes effect on the next enabled step; there is no extra latency.
- Reset asserted mid-count clears state immediately, independent of clk. The first step after release is from 0.
- Latency: 1 cycle from en/load sampled to bin_o/gray_o/wrap_o/sat_o updated.

Optional Feature:
- Macro: GRAY_COUNTER_MOD_ASSERT_EN.
- Defined: the module compiles in concurrent SVA properties, all clocked on posedge clk and disabled while rst is low:
  - p_coh: gray_o == bin_o ^ (bin_o >> 1).
  - p_range: bin_o <= MAX.
  - p_onebit: when MODULO == 0 and the previous cycle had en && !load && !sat_o, then $countones(gray_o ^ $past(gray_o)) <= 1.
  - p_live: (s_eventually always (rst && en && !load)) -> always s_eventually zero_o. Only applies when SAT == 0.
  - p_wrap: wrap_o implies $past(en && !load).
- Undefined: no properties; RTL behaviour is identical.

Test Plan:
- Defaults, release reset, en = 1, up = 1 for 4097 cycles -> bin_o runs 0..4095, then 0 at cycle 4096 with wrap_o = 1 for exactly that cycle; gray_o at bin_o = 3 is 0x002; every step changes exactly one gray_o bit.
- MODULO = 10, up = 1 from 0 -> sequence 0..9, 0; wrap_o pulses once; then up = 0 from 0 -> bin_o = 9, wrap_o = 1.
- SAT = 1, WIDTH = 4, load 14, en = 1, up = 1 for 3 cycles -> bin_o = 15, then held at 15 with sat_o = 1; then up = 0 -> bin_o = 14, sat_o = 0.
- load = 1 with load_val = 0xFFF while en = 1, MODULO = 100 -> bin_o = 99, gray_o = 99 ^ 49 = 82; en is ignored that cycle.
- Counting at bin_o = 0x5A5, drop rst between clock edges -> all outputs 0 immediately, zero_o = 0 while rst is low; after release zero_o = 1 and counting restarts from 0.
- en toggled 1,0,1,0 with up = 1 from 7 -> bin_o = 8, 8, 9, 9; wrap_o stays 0.
